// File: rtl/spm_lsu_pkg.sv
// Shared definitions for the scratchpad load/store unit: size codes, bus
// direction levels, FSM states and the alignment rule.
package spm_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD     = 3'd1,
        RMW_RD = 3'd2,
        ST     = 3'd3,
        ERR    = 3'd4,
        RESP   = 3'd5
    } state_e;

    // Size code 2'b11 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/spm_lsu_align.sv
// Combinational lane logic for the big-endian scratchpad: load extract and
// extend, and sub-word store merge into the word read back from memory.
module spm_lsu_align
    import spm_lsu_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = 8'h00;
        case (addr_lo_i)
            2'd0: lane_b = rd_word_i[31:24];
            2'd1: lane_b = rd_word_i[23:16];
            2'd2: lane_b = rd_word_i[15:8];
            2'd3: lane_b = rd_word_i[7:0];
            default: lane_b = 8'h00;
        endcase
        lane_h = addr_lo_i[1] ? rd_word_i[15:0] : rd_word_i[31:16];
    end

    always_comb begin
        ld_data_o = rd_word_i;
        case (size_i)
            SZ_BYTE: ld_data_o = unsigned_i ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: ld_data_o = unsigned_i ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_data_o = rd_word_i;
        endcase
    end

    always_comb begin
        st_word_o = rd_word_i;
        case (size_i)
            SZ_BYTE: begin
                case (addr_lo_i)
                    2'd0: st_word_o[31:24] = wdata_i[7:0];
                    2'd1: st_word_o[23:16] = wdata_i[7:0];
                    2'd2: st_word_o[15:8]  = wdata_i[7:0];
                    2'd3: st_word_o[7:0]   = wdata_i[7:0];
                    default: st_word_o = rd_word_i;
                endcase
            end
            SZ_HALF: begin
                if (addr_lo_i[1]) st_word_o[15:0]  = wdata_i[15:0];
                else              st_word_o[31:16] = wdata_i[15:0];
            end
            default: st_word_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/spm_lsu.sv
// Load/store unit between the MEM stage and the scratchpad data port.
// Optional address range check: define SPM_LSU_RANGE_CHK_EN.
//
// state  | meaning
// IDLE   | ready for a request
// LD     | read access, capture extended load data
// RMW_RD | read access, capture merged word for a sub-word store
// ST     | write access
// ERR    | faulted request, no access
// RESP   | one-cycle response pulse
module spm_lsu
    import spm_lsu_pkg::*;
#(
    parameter int SPM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_range,
    output logic [29:0] spm_addr,
    output logic        spm_as_,
    output logic        spm_rw,
    output logic [31:0] spm_wr_data,
    input  logic [31:0] spm_rd_data
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        rng_q, rng_d;

    logic        range_hit;
    logic        req_mis;
    logic [31:0] ld_data;
    logic [31:0] st_word;

`ifdef SPM_LSU_RANGE_CHK_EN
    assign range_hit = (req_addr >= 32'(SPM_BYTES));
`else
    logic unused_addr_hi;
    assign range_hit      = 1'b0;
    assign unused_addr_hi = ^{req_addr[31:30], SPM_BYTES == 0};
`endif

    assign req_mis   = is_misaligned(req_size, req_addr[1:0]);
    assign req_ready = (state_q == IDLE) && !rst;

    spm_lsu_align u_align (
        .rd_word_i  (spm_rd_data),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .ld_data_o  (ld_data),
        .st_word_o  (st_word)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        mis_d       = mis_q;
        rng_d       = rng_q;
        rsp_valid   = 1'b0;
        spm_as_     = 1'b1;
        spm_rw      = READ;
        spm_addr    = 30'd0;
        spm_wr_data = 32'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[29:0];
                    wdata_d = req_wdata;
                    rdata_d = 32'd0;
                    mis_d   = req_mis;
                    rng_d   = range_hit;
                    if (req_mis || range_hit) state_d = ERR;
                    else if (!req_we)         state_d = LD;
                    else if (req_size[1])     state_d = ST;
                    else                      state_d = RMW_RD;
                end
            end
            LD: begin
                spm_as_  = 1'b0;
                spm_rw   = READ;
                spm_addr = {addr_q[29:2], 2'b00};
                rdata_d  = ld_data;
                state_d  = RESP;
            end
            RMW_RD: begin
                spm_as_  = 1'b0;
                spm_rw   = READ;
                spm_addr = {addr_q[29:2], 2'b00};
                wdata_d  = st_word;
                state_d  = ST;
            end
            ST: begin
                // wdata_q already holds either the merged or the full store word
                spm_as_     = 1'b0;
                spm_rw      = WRITE;
                spm_addr    = {addr_q[29:2], 2'b00};
                spm_wr_data = wdata_q;
                state_d     = RESP;
            end
            ERR: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= 30'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    assign rsp_rdata    = rdata_q;
    assign rsp_misalign = mis_q;
    assign rsp_range    = rng_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_spm_lsu.sv
// Scoreboard bench for spm_lsu with a byte-array reference model of the
// big-endian scratchpad and a behavioural word-wide scratchpad on the port.
module tb_spm_lsu;

    localparam int SPM_BYTES = 1024;
    localparam int NWORDS    = SPM_BYTES / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_misalign, rsp_range;
    logic [31:0] rsp_rdata;
    logic [29:0] spm_addr;
    logic        spm_as_, spm_rw;
    logic [31:0] spm_wr_data, spm_rd_data;

    spm_lsu #(.SPM_BYTES(SPM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_range(rsp_range),
        .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
        .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scratchpad: combinational read, write on the edge closing a write cycle
    logic [31:0] spm_mem [NWORDS];
    logic [31:0] init_w  [NWORDS];
    logic        init_en = 1'b1;
    assign spm_rd_data = spm_mem[spm_addr[9:2]];
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < NWORDS; i++) spm_mem[i] <= init_w[i];
        end else if (!spm_as_ && !spm_rw) begin
            spm_mem[spm_addr[9:2]] <= spm_wr_data;
        end
    end

    logic [7:0] ref_b [SPM_BYTES];

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        rng;
        int          acc;
        int          lat;
        int          nrd;
        int          nwr;
        logic [29:0] waddr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, output exp_t e);
        int i, b;
        logic [31:0] v;
        logic mis, rng;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && (a % 4) != 0);
        rng = 1'b0;
`ifdef SPM_LSU_RANGE_CHK_EN
        rng = (a >= SPM_BYTES);
`endif
        i = int'(a % SPM_BYTES);
        e.rdata = 0; e.mis = mis; e.rng = rng; e.acc = 0;
        e.lat = 1; e.nrd = 0; e.nwr = 0; e.waddr = {a[29:2], 2'b00};
        if (mis || rng) return;
        if (!we) begin
            e.nrd = 1;
            if (sz == 2'd0) begin
                v = {24'd0, ref_b[i]};
                e.rdata = (!uns && v >= 128) ? v + 32'hFFFF_FF00 : v;
            end else if (sz == 2'd1) begin
                b = i - (i % 2);
                v = {16'd0, ref_b[b], ref_b[b+1]};
                e.rdata = (!uns && v >= 32768) ? v + 32'hFFFF_0000 : v;
            end else begin
                b = i - (i % 4);
                e.rdata = {ref_b[b], ref_b[b+1], ref_b[b+2], ref_b[b+3]};
            end
        end else begin
            e.nwr = 1;
            if (sz == 2'd0) begin
                e.nrd = 1; e.lat = 2;
                ref_b[i] = wd[7:0];
            end else if (sz == 2'd1) begin
                e.nrd = 1; e.lat = 2;
                b = i - (i % 2);
                ref_b[b] = wd[15:8]; ref_b[b+1] = wd[7:0];
            end else begin
                b = i - (i % 4);
                ref_b[b] = wd[31:24]; ref_b[b+1] = wd[23:16];
                ref_b[b+2] = wd[15:8]; ref_b[b+3] = wd[7:0];
            end
        end
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        ok = req_ready;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL ready_timeout: req_ready still 0 after 50 cycles, expected 1");
        end
    endtask

    // Called 1 time unit after a rising edge
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        model(we, sz, uns, a, wd, e);
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        int nrd = 0, nwr = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                chk("ready_low_in_flight", 32'(req_ready), 32'd0);
                if (!spm_as_) begin
                    if (spm_rw) nrd++; else nwr++;
                    chk("spm_addr", 32'(spm_addr), 32'(sb[0].waddr));
                end
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
                    chk("rsp_range", 32'(rsp_range), 32'(e.rng));
                    chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                    chk("read_cycles", 32'(nrd), 32'(e.nrd));
                    chk("write_cycles", 32'(nwr), 32'(e.nwr));
                end
                nrd = 0; nwr = 0;
            end
        end
    end

    initial begin : stim
        bit ok;
        int t;
        logic [31:0] a;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int w = 0; w < NWORDS; w++) init_w[w] = $urandom;
        init_w[32'h40 / 4] = 32'h12F4_5678;
        init_w[32'h80 / 4] = 32'hAABB_CCDD;
        for (int w = 0; w < NWORDS; w++) begin
            ref_b[4*w]   = init_w[w][31:24];
            ref_b[4*w+1] = init_w[w][23:16];
            ref_b[4*w+2] = init_w[w][15:8];
            ref_b[4*w+3] = init_w[w][7:0];
        end
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_misalign", 32'(rsp_misalign), 32'd0);
        chk("rst_range", 32'(rsp_range), 32'd0);
        chk("rst_as", 32'(spm_as_), 32'd1);
        chk("rst_rw", 32'(spm_rw), 32'd1);
        chk("rst_addr", 32'(spm_addr), 32'd0);
        chk("rst_wr_data", spm_wr_data, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        init_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        issue(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h41, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h83, 32'h0000_0011);
        issue(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h102, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);

        // Reset while the half store is in its read phase: no write may land
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
            req_addr = 32'h44; req_wdata = 32'h0000_9999;
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk("rmw_rd_active", 32'(spm_as_), 32'd0);
            rst = 1'b1;
            #1;
            chk("rst_mid_as", 32'(spm_as_), 32'd1);
            chk("rst_mid_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("rst_mid_ready_after", 32'(req_ready), 32'd1);
            issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
        end

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) a = $urandom_range(SPM_BYTES, 4 * SPM_BYTES - 1);
            else                           a = $urandom_range(0, SPM_BYTES - 1);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom);
            t = $urandom_range(0, 2);
            for (int k = 0; k < t; k++) begin
                @(posedge clk); #1;
            end
        end

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("responses_drained", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        for (int w = 0; w < NWORDS; w++)
            chk("mem_word", spm_mem[w], {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
